// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller with a one-entry
// output register and redirect handling (FETCH / WAIT / DRAIN).
// Optional build macro FETCH_CTRL_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {StFetch, StWait, StDrain} state_e;

    state_e      r_state;
    logic [31:0] r_pc;        // address currently presented to memory
    logic [31:0] r_redir_pc;  // redirect target parked while a stale request drains
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    logic        w_slot_free;
    logic        w_req;
    logic        w_ack;
    logic        w_load;
    logic        w_xfer;
    logic [31:0] w_redir_tgt;
    logic [31:0] w_reset_pc;
    logic [31:0] w_pc_inc;

    assign w_slot_free = !r_valid || instr_ready;
    assign w_ack       = w_req && imem_ack;
    // Data acked in DRAIN or alongside a redirect belongs to a stale stream.
    assign w_load      = w_ack && !redirect && (r_state != StDrain);
    assign w_xfer      = r_valid && instr_ready;
    // Masking keeps every input bit used while forcing word alignment.
    assign w_redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign w_reset_pc  = RESET_PC & 32'hFFFF_FFFC;
    assign w_pc_inc    = r_pc + 32'd4;

    // Request generation: FETCH only asks when the output slot can take data.
    always_comb begin
        w_req = 1'b1;
        if (r_state == StFetch) begin
            w_req = w_slot_free;
        end
        if (reset) begin
            w_req = 1'b0;
        end
    end

    // FSM, fetch PC and output register; redirect takes priority over normal flow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StFetch;
            r_pc       <= w_reset_pc;
            r_redir_pc <= w_reset_pc;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
        end else begin
            if (w_load) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
                r_valid    <= 1'b1;
            end else if (redirect || w_xfer) begin
                r_valid <= 1'b0;
            end

            if (redirect) begin
                r_redir_pc <= w_redir_tgt;
                if (w_req && !imem_ack) begin
                    // Keep the stale address on the bus until its ack arrives.
                    r_state <= StDrain;
                end else begin
                    r_state <= StFetch;
                    r_pc    <= w_redir_tgt;
                end
            end else begin
                unique case (r_state)
                    StFetch: begin
                        if (w_ack) begin
                            r_pc <= w_pc_inc;
                        end else if (w_req) begin
                            r_state <= StWait;
                        end
                    end
                    StWait: begin
                        if (w_ack) begin
                            r_pc    <= w_pc_inc;
                            r_state <= StFetch;
                        end
                    end
                    StDrain: begin
                        if (w_ack) begin
                            r_pc    <= r_redir_pc;
                            r_state <= StFetch;
                        end
                    end
                    default: r_state <= StFetch;
                endcase
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Event counters: delivered instructions and cycles spent waiting on memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_xfer) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_req && !imem_ack) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule
